// File: rtl/parc_core_fill_arbiter.sv
// Completion collector ahead of the ROB fill port.
// Each functional unit has its own small FIFO of finished results. One result
// per cycle is granted round-robin and drives the ROB fill and RF write.
module parc_core_fill_arbiter #(
    parameter int unsigned NSRC   = 3,
    parameter int unsigned DEPTH  = 2,
    parameter int unsigned SLOT_W = 4,
    parameter int unsigned PREG_W = 5,
    parameter int unsigned DATA_W = 32,
    localparam int unsigned GSRC_W = (NSRC > 1) ? $clog2(NSRC) : 1
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [NSRC-1:0]          fu_val,
    output logic [NSRC-1:0]          fu_rdy,
    input  logic [NSRC*SLOT_W-1:0]   fu_slot,
    input  logic [NSRC*PREG_W-1:0]   fu_preg,
    input  logic [NSRC*DATA_W-1:0]   fu_data,
    input  logic                     wb_stall,
    output logic                     rob_fill_val,
    output logic [SLOT_W-1:0]        rob_fill_slot,
    output logic                     rf_wen,
    output logic [PREG_W-1:0]        rf_waddr,
    output logic [DATA_W-1:0]        rf_wdata,
    output logic [GSRC_W-1:0]        grant_src
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    // Per-source FIFO storage
    logic [SLOT_W-1:0] r_slot [NSRC][DEPTH];
    logic [PREG_W-1:0] r_preg [NSRC][DEPTH];
    logic [DATA_W-1:0] r_data [NSRC][DEPTH];

    // Per-source FIFO control and arbitration pointer
    logic [PTR_W-1:0]  r_wr_ptr [NSRC];
    logic [PTR_W-1:0]  r_rd_ptr [NSRC];
    logic [CNT_W-1:0]  r_count  [NSRC];
    logic [GSRC_W-1:0] r_rr_ptr;

    logic [NSRC-1:0]   w_push;
    logic [NSRC-1:0]   w_pop;
    logic [NSRC-1:0]   w_elig;
    logic              w_found;
    logic              w_grant;
    logic [GSRC_W-1:0] w_gidx;
    logic [GSRC_W:0]   w_scan;

    // Ready, push and eligibility come from registered counts only
    always_comb begin
        fu_rdy = '0;
        w_push = '0;
        w_elig = '0;
        for (int i = 0; i < int'(NSRC); i++) begin
            w_elig[i] = (r_count[i] != '0);
            fu_rdy[i] = reset && (r_count[i] < CNT_W'(DEPTH));
            w_push[i] = fu_val[i] && fu_rdy[i];
        end
    end

    // Round-robin scan starting at rr_ptr; stall or reset suppresses the grant
    always_comb begin
        w_found = 1'b0;
        w_gidx  = '0;
        w_scan  = '0;
        for (int k = 0; k < int'(NSRC); k++) begin
            w_scan = (GSRC_W+1)'(r_rr_ptr) + (GSRC_W+1)'(k);
            if (w_scan >= (GSRC_W+1)'(NSRC)) begin
                w_scan = w_scan - (GSRC_W+1)'(NSRC);
            end
            for (int j = 0; j < int'(NSRC); j++) begin
                if (!w_found && w_elig[j] && (w_scan == (GSRC_W+1)'(j))) begin
                    w_found = 1'b1;
                    w_gidx  = GSRC_W'(j);
                end
            end
        end
        w_grant = w_found && !wb_stall && reset;
        w_pop   = '0;
        for (int i = 0; i < int'(NSRC); i++) begin
            w_pop[i] = w_grant && (w_gidx == GSRC_W'(i));
        end
    end

    // Writeback outputs muxed from the granted FIFO head, zero when idle
    always_comb begin
        rob_fill_val  = 1'b0;
        rf_wen        = 1'b0;
        rob_fill_slot = '0;
        rf_waddr      = '0;
        rf_wdata      = '0;
        grant_src     = '0;
        if (w_grant) begin
            rob_fill_val = 1'b1;
            rf_wen       = 1'b1;
            grant_src    = w_gidx;
            for (int j = 0; j < int'(NSRC); j++) begin
                if (w_pop[j]) begin
                    rob_fill_slot = r_slot[j][r_rd_ptr[j]];
                    rf_waddr      = r_preg[j][r_rd_ptr[j]];
                    rf_wdata      = r_data[j][r_rd_ptr[j]];
                end
            end
        end
    end

    // FIFO pointers, occupancy and round-robin pointer
    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int i = 0; i < int'(NSRC); i++) begin
                r_wr_ptr[i] <= '0;
                r_rd_ptr[i] <= '0;
                r_count[i]  <= '0;
            end
            r_rr_ptr <= '0;
        end else begin
            for (int i = 0; i < int'(NSRC); i++) begin
                if (w_push[i]) begin
                    r_wr_ptr[i] <= r_wr_ptr[i] + PTR_W'(1);
                end
                if (w_pop[i]) begin
                    r_rd_ptr[i] <= r_rd_ptr[i] + PTR_W'(1);
                end
                if (w_push[i] && !w_pop[i]) begin
                    r_count[i] <= r_count[i] + CNT_W'(1);
                end else if (w_pop[i] && !w_push[i]) begin
                    r_count[i] <= r_count[i] - CNT_W'(1);
                end
            end
            if (w_grant) begin
                r_rr_ptr <= (w_gidx == GSRC_W'(NSRC - 1)) ? '0 : (w_gidx + GSRC_W'(1));
            end
        end
    end

    // Payload storage; contents are only meaningful while counted as valid
    always_ff @(posedge clk) begin
        for (int i = 0; i < int'(NSRC); i++) begin
            if (w_push[i]) begin
                r_slot[i][r_wr_ptr[i]] <= fu_slot[i*SLOT_W +: SLOT_W];
                r_preg[i][r_wr_ptr[i]] <= fu_preg[i*PREG_W +: PREG_W];
                r_data[i][r_wr_ptr[i]] <= fu_data[i*DATA_W +: DATA_W];
            end
        end
    end

endmodule
